pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the main decoder (opcode -> control flags).
- Consumes the decoder's jump/branch/bltzal/jspal/baln flags plus ALU status.
- Holds PC and a sticky N status flag, and computes next PC on each committed instruction.
- Supplies the link address to the writeback mux, plus a retired-instruction counter and a misalignment flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_valid  input  1  fetched instruction at pc is valid this cycle
stall  input  1  hold PC and state; no commit
branch  input  1  beq flag from decoder
jump  input  1  j flag from decoder
bltzal  input  1  bltzal flag from decoder
jspal  input  1  jspal flag from decoder
baln  input  1  baln flag from decoder
alu_zero  input  1  ALU result == 0 (beq compare)
alu_neg  input  1  ALU result bit 31 (bltzal test of rs)
flag_we  input  1  update stored N flag this commit
flag_n_in  input  1  new N value (ALU result bit 31)
sext_imm  input  32  sign-extended 16-bit immediate
jtarget  input  26  instruction[25:0]
jsp_target  input  32  register-sourced target for jspal
pc  output  32  current PC (instruction address)
pc_plus4  output  32  pc + 4
link_addr  output  32  return address for writeback (= pc_plus4)
link_we  output  1  select link_addr into register file this commit
flag_n  output  1  stored N status flag
retire  output  1  one-cycle pulse per committed instruction
redirect  output  1  next PC is not pc+4 (committing cycle)
retired_cnt  output  CNT_W  committed instruction count
align_err  output  1  sticky: jspal target had nonzero bits [1:0]

Behaviour:
- Reset (async, immediate): pc=RESET_PC, flag_n=0, retired_cnt=0, align_err=0, state=BOOT. retire, link_we and redirect are 0 while reset is held.
- FSM states:
  - BOOT: one cycle after reset deassert, no commit, -> RUN.
  - RUN: commit = imem_valid & ~stall. stall=1 -> HOLD.
  - HOLD: no commit; PC, flags and counter frozen. -> RUN on the first cycle with stall=0; a commit can occur in that same cycle.
- A commit takes effect at the rising edge at the end of the commit cycle.
- retire = commit, combinational. link_we = commit & (bltzal | baln); both link unconditionally.
- Taken conditions:
  - beq_t = branch & alu_zero
  - bltzal_t = bltzal & alu_neg
  - baln_t = baln & flag_n, using the stored flag_n before any same-cycle update
- Next-PC priority: jump > jspal > (beq_t | bltzal_t | baln_t) > sequential.
  - jump: {pc_plus4[31:28], jtarget, 2'b00}
  - jspal: {jsp_target[31:2], 2'b00}; if jsp_target[1:0] != 0, set align_err (sticky until reset)
  - branch: pc_plus4 + (sext_imm << 2), mod 2^32 wrap
  - sequential: pc_plus4, which wraps 32'hFFFF_FFFC -> 0
- redirect = commit & (next PC != pc_plus4 path selected). Selection-based: a taken branch with offset 0 still asserts redirect.
- flag_n <= flag_n_in when commit & flag_we. The new value is visible to baln on the next commit only.
- retired_cnt increments by 1 on commit, wraps at 2^CNT_W.
- Multiple flags asserted at once: the priority above governs the PC; link_we still follows bltzal|baln.
- No commit when imem_valid=0: outputs pc/pc_plus4 hold, retire=0.

Decomposition:
- Shared package mips_lite_pkg holds:
  - opcode constants (J=2, BEQ=4, ORI=13, JSPAL=19, BALN=27, BLTZAL=34, LW=35, SW=43)
  - FSM state typedef {BOOT, RUN, HOLD}
  - RESET_PC default
- One natural sub-module, pc_target_mux: combinational taken-logic, priority and target computation.
- The FSM, flag, counter and align_err registers stay in pc_sequencer.

Test Plan:
1. Reset then imem_valid=1, no flags for 3 cycles -> pc 0 -> 4 -> 8 -> C; retire pulses 3; retired_cnt=3; BOOT cycle shows no retire.
2. pc=0x100, branch=1, alu_zero=1, sext_imm=0xFFFF_FFFE -> next pc=0x0FC, redirect=1. Same with alu_zero=0 -> 0x104, redirect=0.
3. pc=0x200, bltzal=1, alu_neg=0, sext_imm=4 -> link_we=1, link_addr=0x204, next pc=0x204. With alu_neg=1 -> next pc=0x214.
4. Commit with flag_we=1, flag_n_in=1, then baln=1, sext_imm=8 at pc=0x300 -> next pc=0x324, link_addr=0x304. baln in the same cycle as the flag write uses the old flag_n=0.
5. pc=0xF000_0010, jump=1, jspal=1, jtarget=0x0000040, jsp_target=0x123 -> jump wins: pc=0xF000_0100, align_err stays 0. Then jspal alone with jsp_target=0x123 -> pc=0x120, align_err=1 (sticky).
6. stall=1 for 4 cycles mid-run -> pc and retired_cnt frozen, retire=0. Async reset asserted mid-HOLD -> pc=RESET_PC immediately, counter=0, state BOOT.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// Shared definitions for the mips_lite pipeline: opcodes, sequencer states, reset vector.
package mips_lite_pkg;

    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_JSPAL  = 6'd19;
    localparam logic [5:0] OP_BALN   = 6'd27;
    localparam logic [5:0] OP_BLTZAL = 6'd34;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC selection: evaluates taken conditions and picks the target by priority
// jump > jspal > taken branch > sequential.
module pc_target_mux
    import mips_lite_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        bltzal,
    input  logic        jspal,
    input  logic        baln,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        flag_n,
    input  logic [31:0] sext_imm,
    input  logic [25:0] jtarget,
    input  logic [31:0] jsp_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        take_redirect,
    output logic        jsp_misaligned
);

    logic [31:0] branch_target;
    logic        branch_taken;

    // Target arithmetic and priority select; redirect follows the selected path, not the value.
    always_comb begin
        pc_plus4       = pc + 32'd4;
        branch_target  = pc_plus4 + (sext_imm << 2);
        branch_taken   = (branch & alu_zero) | (bltzal & alu_neg) | (baln & flag_n);
        next_pc        = pc_plus4;
        take_redirect  = 1'b0;
        jsp_misaligned = 1'b0;
        if (jump) begin
            next_pc       = {pc_plus4[31:28], jtarget, 2'b00};
            take_redirect = 1'b1;
        end else if (jspal) begin
            next_pc        = {jsp_target[31:2], 2'b00};
            take_redirect  = 1'b1;
            jsp_misaligned = |jsp_target[1:0];
        end else if (branch_taken) begin
            next_pc       = branch_target;
            take_redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds PC, sticky N flag, retire counter and alignment error,
// committing one instruction per cycle when fetch is valid and not stalled.
module pc_sequencer
    import mips_lite_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             branch,
    input  logic             jump,
    input  logic             bltzal,
    input  logic             jspal,
    input  logic             baln,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             flag_we,
    input  logic             flag_n_in,
    input  logic [31:0]      sext_imm,
    input  logic [25:0]      jtarget,
    input  logic [31:0]      jsp_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      link_addr,
    output logic             link_we,
    output logic             flag_n,
    output logic             retire,
    output logic             redirect,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             align_err
);

    seq_state_t  state;
    seq_state_t  next_state;
    logic        commit;
    logic [31:0] next_pc;
    logic        take_redirect;
    logic        jsp_misaligned;

    pc_target_mux u_target_mux (
        .pc             (pc),
        .branch         (branch),
        .jump           (jump),
        .bltzal         (bltzal),
        .jspal          (jspal),
        .baln           (baln),
        .alu_zero       (alu_zero),
        .alu_neg        (alu_neg),
        .flag_n         (flag_n),
        .sext_imm       (sext_imm),
        .jtarget        (jtarget),
        .jsp_target     (jsp_target),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .take_redirect  (take_redirect),
        .jsp_misaligned (jsp_misaligned)
    );

    // State register; reset parks the sequencer in BOOT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and commit decode; leaving HOLD may commit in the same cycle.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                commit = imem_valid & ~stall;
                if (stall) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                commit = imem_valid & ~stall;
                if (!stall) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // Architectural registers update only on a commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            flag_n      <= 1'b0;
            retired_cnt <= '0;
            align_err   <= 1'b0;
        end else if (commit) begin
            pc          <= next_pc;
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flag_we) begin
                flag_n <= flag_n_in;
            end
            if (jsp_misaligned) begin
                align_err <= 1'b1;
            end
        end
    end

    // Commit-cycle strobes; bltzal and baln link whether or not they are taken.
    always_comb begin
        retire    = commit;
        link_we   = commit & (bltzal | baln);
        redirect  = commit & take_redirect;
        link_addr = pc_plus4;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_valid;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        bltzal;
    logic        jspal;
    logic        baln;
    logic        alu_zero;
    logic        alu_neg;
    logic        flag_we;
    logic        flag_n_in;
    logic [31:0] sext_imm;
    logic [25:0] jtarget;
    logic [31:0] jsp_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        link_we;
    logic        flag_n;
    logic        retire;
    logic        redirect;
    logic [31:0] retired_cnt;
    logic        align_err;

    int          totalCount = 0;
    int          badCount   = 0;
    logic [31:0] expPc;
    logic [31:0] expCnt;

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .bltzal      (bltzal),
        .jspal       (jspal),
        .baln        (baln),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .flag_we     (flag_we),
        .flag_n_in   (flag_n_in),
        .sext_imm    (sext_imm),
        .jtarget     (jtarget),
        .jsp_target  (jsp_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .link_addr   (link_addr),
        .link_we     (link_we),
        .flag_n      (flag_n),
        .retire      (retire),
        .redirect    (redirect),
        .retired_cnt (retired_cnt),
        .align_err   (align_err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    task automatic clearFlags();
        branch     = 1'b0;
        jump       = 1'b0;
        bltzal     = 1'b0;
        jspal      = 1'b0;
        baln       = 1'b0;
        alu_zero   = 1'b0;
        alu_neg    = 1'b0;
        flag_we    = 1'b0;
        flag_n_in  = 1'b0;
        sext_imm   = 32'd0;
        jtarget    = 26'd0;
        jsp_target = 32'd0;
    endtask

    // Inputs must already be driven (just after a rising edge); checks the commit strobes,
    // advances one clock, then checks the committed PC and counter.
    task automatic applyStimulus(input string tag, input logic [31:0] expNext,
                                 input logic expRedirect, input logic expLinkWe);
        #1;
        checkOutput({tag, ".retire"}, {31'd0, retire}, 32'd1);
        checkOutput({tag, ".redirect"}, {31'd0, redirect}, {31'd0, expRedirect});
        checkOutput({tag, ".link_we"}, {31'd0, link_we}, {31'd0, expLinkWe});
        checkOutput({tag, ".link_addr"}, link_addr, expPc + 32'd4);
        @(posedge clk);
        #1;
        expPc  = expNext;
        expCnt = expCnt + 32'd1;
        checkOutput({tag, ".pc"}, pc, expPc);
        checkOutput({tag, ".cnt"}, retired_cnt, expCnt);
        clearFlags();
    endtask

    initial begin
        clearFlags();
        reset      = 1'b1;
        imem_valid = 1'b1;
        stall      = 1'b0;
        expPc      = 32'h0;
        expCnt     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.pc", pc, 32'h0);
        checkOutput("rst.cnt", retired_cnt, 32'd0);
        checkOutput("rst.flag_n", {31'd0, flag_n}, 32'd0);
        checkOutput("rst.align", {31'd0, align_err}, 32'd0);
        checkOutput("rst.retire", {31'd0, retire}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("boot.retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("boot.pc", pc, 32'h0);

        // Sequential fetch.
        applyStimulus("seq0", 32'h4, 1'b0, 1'b0);
        applyStimulus("seq1", 32'h8, 1'b0, 1'b0);
        applyStimulus("seq2", 32'hC, 1'b0, 1'b0);

        // beq taken backwards and not taken.
        jump = 1'b1; jtarget = 26'h40;
        applyStimulus("j100", 32'h100, 1'b1, 1'b0);
        branch = 1'b1; alu_zero = 1'b1; sext_imm = 32'hFFFF_FFFE;
        applyStimulus("beq_t", 32'h0FC, 1'b1, 1'b0);
        applyStimulus("seq_fc", 32'h100, 1'b0, 1'b0);
        branch = 1'b1; alu_zero = 1'b0; sext_imm = 32'hFFFF_FFFE;
        applyStimulus("beq_nt", 32'h104, 1'b0, 1'b0);

        // bltzal links whether or not taken.
        jump = 1'b1; jtarget = 26'h80;
        applyStimulus("j200a", 32'h200, 1'b1, 1'b0);
        bltzal = 1'b1; alu_neg = 1'b0; sext_imm = 32'd4;
        applyStimulus("bltzal_nt", 32'h204, 1'b0, 1'b1);
        jump = 1'b1; jtarget = 26'h80;
        applyStimulus("j200b", 32'h200, 1'b1, 1'b0);
        bltzal = 1'b1; alu_neg = 1'b1; sext_imm = 32'd4;
        applyStimulus("bltzal_t", 32'h214, 1'b1, 1'b1);

        // baln in the flag-write cycle sees the old flag.
        baln = 1'b1; sext_imm = 32'd8; flag_we = 1'b1; flag_n_in = 1'b1;
        applyStimulus("baln_old", 32'h218, 1'b0, 1'b1);
        checkOutput("flag_n.set", {31'd0, flag_n}, 32'd1);
        jump = 1'b1; jtarget = 26'hC0;
        applyStimulus("j300", 32'h300, 1'b1, 1'b0);
        baln = 1'b1; sext_imm = 32'd8;
        applyStimulus("baln_t", 32'h324, 1'b1, 1'b1);

        // Jump beats jspal; misaligned jspal sets sticky align_err.
        jspal = 1'b1; jsp_target = 32'hF000_0010;
        applyStimulus("jsp_hi", 32'hF000_0010, 1'b1, 1'b0);
        checkOutput("align.clean", {31'd0, align_err}, 32'd0);
        jump = 1'b1; jspal = 1'b1; jtarget = 26'h40; jsp_target = 32'h123;
        applyStimulus("j_over_jsp", 32'hF000_0100, 1'b1, 1'b0);
        checkOutput("align.jwins", {31'd0, align_err}, 32'd0);
        jspal = 1'b1; jsp_target = 32'h123;
        applyStimulus("jsp_mis", 32'h120, 1'b1, 1'b0);
        checkOutput("align.set", {31'd0, align_err}, 32'd1);
        applyStimulus("seq_120", 32'h124, 1'b0, 1'b0);
        checkOutput("align.sticky", {31'd0, align_err}, 32'd1);

        // Sequential wrap at the top of the address space.
        jspal = 1'b1; jsp_target = 32'hFFFF_FFFC;
        applyStimulus("jsp_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        #1;
        checkOutput("wrap.plus4", pc_plus4, 32'h0);
        applyStimulus("seq_wrap", 32'h0, 1'b0, 1'b0);

        // Invalid fetch holds everything.
        imem_valid = 1'b0;
        #1;
        checkOutput("inv.retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("inv.pc", pc, expPc);
        checkOutput("inv.cnt", retired_cnt, expCnt);
        imem_valid = 1'b1;

        // Four stalled cycles, then a commit on the release cycle.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("stall.retire", {31'd0, retire}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput("stall.pc", pc, expPc);
            checkOutput("stall.cnt", retired_cnt, expCnt);
        end
        stall = 1'b0;
        applyStimulus("unstall", 32'h4, 1'b0, 1'b0);

        // Async reset in the middle of HOLD.
        stall = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("hrst.pc", pc, 32'h0);
        checkOutput("hrst.cnt", retired_cnt, 32'd0);
        checkOutput("hrst.retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        expPc  = 32'h0;
        expCnt = 32'd0;
        #1;
        checkOutput("hboot.retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hboot.pc", pc, 32'h0);
        applyStimulus("post_rst", 32'h4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
